// File: rtl/pipe_if_branch_predictor_if.sv
// Bundle of signals between the IF-stage branch predictor and its environment.
// The master drives fetch PC and ID-stage update requests. The slave (the
// predictor) returns the prediction and the event counters.
interface pipe_if_branch_predictor_if;
  logic [31:0] pc;
  logic        wpcir;
  logic        ud_BTB;
  logic        ud_pdt;
  logic [31:0] upd_pc;
  logic        real_taken;
  logic [31:0] real_bjpc;
  logic        pre_fch_wrong;
  logic        pre_taken;
  logic [31:0] pre_bjpc;
  logic [15:0] br_cnt;
  logic [15:0] miss_cnt;

  modport master (
    output pc, wpcir, ud_BTB, ud_pdt, upd_pc, real_taken, real_bjpc, pre_fch_wrong,
    input  pre_taken, pre_bjpc, br_cnt, miss_cnt
  );

  modport slave (
    input  pc, wpcir, ud_BTB, ud_pdt, upd_pc, real_taken, real_bjpc, pre_fch_wrong,
    output pre_taken, pre_bjpc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/pipe_if_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the IF stage.
// Lookup is purely combinational on the fetch PC and has no write bypass.
// The ID stage trains or allocates entries one cycle later, gated by wpcir.
module pipe_if_branch_predictor #(
  parameter int IDX_W = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  pipe_if_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  // Saturating counter step toward strong-taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    case (c)
      2'b11:   ctr_inc = 2'b11;
      default: ctr_inc = c + 2'd1;
    endcase
  endfunction

  // Saturating counter step toward strong-not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    case (c)
      2'b00:   ctr_dec = 2'b00;
      default: ctr_dec = c - 2'd1;
    endcase
  endfunction

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];
  logic [15:0]      br_cnt_r;
  logic [15:0]      miss_cnt_r;

  logic [IDX_W-1:0] look_idx_s;
  logic [TAG_W-1:0] look_tag_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             look_hit_s;
  logic             upd_hit_s;
  logic             taken_s;
  logic [31:0]      bjpc_s;
  logic             accept_upd_s;
  logic             accept_miss_s;
  logic             unused_s;

  assign look_idx_s = bp.pc[IDX_W+1:2];
  assign look_tag_s = bp.pc[31:IDX_W+2];
  assign upd_idx_s  = bp.upd_pc[IDX_W+1:2];
  assign upd_tag_s  = bp.upd_pc[31:IDX_W+2];
  // Byte offset of the update PC does not select anything.
  assign unused_s   = ^bp.upd_pc[1:0];

  assign accept_upd_s  = bp.wpcir & (bp.ud_BTB | bp.ud_pdt);
  assign accept_miss_s = bp.wpcir & bp.pre_fch_wrong;

  // Zero-latency lookup: hit detection and next-PC selection from pre-edge contents.
  always_comb begin
    look_hit_s = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
    upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    taken_s    = look_hit_s & ctr_r[look_idx_s][1];
    if (taken_s) begin
      bjpc_s = target_r[look_idx_s];
    end else begin
      bjpc_s = bp.pc + 32'd4;
    end
  end

  assign bp.pre_taken = taken_s;
  assign bp.pre_bjpc  = bjpc_s;
  assign bp.br_cnt    = br_cnt_r;
  assign bp.miss_cnt  = miss_cnt_r;

  // BTB entry allocation (ud_BTB wins) and counter/target training on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (bp.wpcir) begin
      if (bp.ud_BTB) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= bp.real_bjpc;
        ctr_r[upd_idx_s]    <= bp.real_taken ? 2'b10 : 2'b01;
      end else if (bp.ud_pdt && upd_hit_s) begin
        if (bp.real_taken) begin
          ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
          target_r[upd_idx_s] <= bp.real_bjpc;
        end else begin
          ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
        end
      end
    end
  end

  // Saturating event counters; both may step on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_r   <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else begin
      if (accept_upd_s && (br_cnt_r != 16'hFFFF)) begin
        br_cnt_r <= br_cnt_r + 16'd1;
      end
      if (accept_miss_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_if_branch_predictor.sv
// Scoreboard bench for pipe_if_branch_predictor: directed vectors push
// hand-computed expectations, a monitor pops and compares on each sample.
module tb_pipe_if_branch_predictor;
  logic clk;
  logic rst_n;

  pipe_if_branch_predictor_if bp_if ();

  pipe_if_branch_predictor #(.IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if.slave)
  );

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] bjpc;
    logic [15:0] br;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop one expectation per sample strobe and compare.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty: sample with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (bp_if.pre_taken !== e.taken || bp_if.pre_bjpc !== e.bjpc ||
            bp_if.br_cnt !== e.br || bp_if.miss_cnt !== e.miss) begin
          tests_failed++;
          $display("FAIL %s: got taken=%0b bjpc=%h br=%0d miss=%0d, want taken=%0b bjpc=%h br=%0d miss=%0d",
                   e.name, bp_if.pre_taken, bp_if.pre_bjpc, bp_if.br_cnt, bp_if.miss_cnt,
                   e.taken, e.bjpc, e.br, e.miss);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.wpcir         = 1'b1;
    bp_if.ud_BTB        = 1'b0;
    bp_if.ud_pdt        = 1'b0;
    bp_if.upd_pc        = 32'd0;
    bp_if.real_taken    = 1'b0;
    bp_if.real_bjpc     = 32'd0;
    bp_if.pre_fch_wrong = 1'b0;
  endtask

  task automatic set_upd(input logic btb, input logic pdt, input logic [31:0] upc,
                         input logic rt, input logic [31:0] rb);
    bp_if.ud_BTB     = btb;
    bp_if.ud_pdt     = pdt;
    bp_if.upd_pc     = upc;
    bp_if.real_taken = rt;
    bp_if.real_bjpc  = rb;
  endtask

  // One accepted update edge, then back to idle inputs.
  task automatic upd(input logic btb, input logic pdt, input logic [31:0] upc,
                     input logic rt, input logic [31:0] rb);
    set_upd(btb, pdt, upc, rt, rb);
    tick();
    idle();
  endtask

  task automatic look(input string name, input logic [31:0] pcv, input logic et,
                      input logic [31:0] eb, input logic [15:0] ebr, input logic [15:0] emiss);
    exp_t e;
    bp_if.pc = pcv;
    e.name  = name;
    e.taken = et;
    e.bjpc  = eb;
    e.br    = ebr;
    e.miss  = emiss;
    exp_q.push_back(e);
    #1;
    -> sample_ev;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bp_if.pc = 32'h0040_0010;
    #2;
    look("in_reset", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    look("after_reset", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd0, 16'd0);
    look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 16'd0, 16'd0);

    // Allocate taken entry; same-cycle lookup sees old contents.
    set_upd(1'b1, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0100);
    look("no_bypass", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd0, 16'd0);
    tick();
    idle();
    look("btb_alloc", 32'h0040_0010, 1'b1, 32'h0040_0100, 16'd1, 16'd0);

    // Train down 10->01->00->00.
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0bad);
    look("dec_01", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd2, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0bad);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0bad);
    look("dec_sat00", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd4, 16'd0);

    // Train up 00->01->10 with target rewrite, then 11 saturation.
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0200);
    look("inc_01", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd5, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300);
    look("inc_10_tgt", 32'h0040_0010, 1'b1, 32'h0040_0300, 16'd6, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0300);
    upd(1'b0, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0bad);
    look("sat11_dec10", 32'h0040_0010, 1'b1, 32'h0040_0300, 16'd9, 16'd0);

    // Alias: same index, different tag.
    look("alias_lookup", 32'h0040_0050, 1'b0, 32'h0040_0054, 16'd9, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0050, 1'b0, 32'h0040_0bad);
    look("alias_no_train", 32'h0040_0010, 1'b1, 32'h0040_0300, 16'd10, 16'd0);

    // Not-taken allocation, training and ud_BTB precedence on index 9.
    upd(1'b1, 1'b0, 32'h0040_0024, 1'b0, 32'h0040_0800);
    look("alloc_nt", 32'h0040_0024, 1'b0, 32'h0040_0028, 16'd11, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0804);
    look("nt_to_taken", 32'h0040_0024, 1'b1, 32'h0040_0804, 16'd12, 16'd0);
    upd(1'b0, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0804);
    upd(1'b1, 1'b1, 32'h0040_0024, 1'b0, 32'h0040_0900);
    look("btb_precedence", 32'h0040_0024, 1'b0, 32'h0040_0028, 16'd14, 16'd0);

    // Stall: request held five cycles with wpcir low.
    set_upd(1'b1, 1'b0, 32'h0040_0010, 1'b0, 32'h0040_0bbb);
    bp_if.pre_fch_wrong = 1'b1;
    bp_if.wpcir         = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    look("stall_hold", 32'h0040_0010, 1'b1, 32'h0040_0300, 16'd14, 16'd0);
    bp_if.wpcir = 1'b1;
    tick();
    idle();
    look("stall_release", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd15, 16'd1);

    // Drive miss_cnt to saturation.
    bp_if.pre_fch_wrong = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    look("miss_ffff", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd15, 16'hFFFF);
    tick();
    look("miss_sat", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd15, 16'hFFFF);

    // Reset mid-update: takes effect without a clock edge, update discarded.
    set_upd(1'b1, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0c00);
    rst_n = 1'b0;
    look("async_reset", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd0, 16'd0);
    look("async_reset_b", 32'h0040_0024, 1'b0, 32'h0040_0028, 16'd0, 16'd0);
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    look("post_reset_a", 32'h0040_0010, 1'b0, 32'h0040_0014, 16'd0, 16'd0);
    look("post_reset_b", 32'h0040_0024, 1'b0, 32'h0040_0028, 16'd0, 16'd0);

    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipe_if_branch_predictor.md
PIPE_IF_BRANCH_PREDICTOR -- requirements
Module: pipe_if_branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, BTB index width; the BTB has 2^IDX_W direct-mapped entries.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 pc  input  32  fetch PC of the IF stage, used for lookup.
REQ-005 wpcir  input  1  pipeline-advance enable from ID; 0 = ID stalled.
REQ-006 ud_BTB  input  1  ID request: allocate or overwrite the entry for upd_pc.
REQ-007 ud_pdt  input  1  ID request: train the existing entry for upd_pc.
REQ-008 upd_pc  input  32  PC of the branch or jump currently in ID.
REQ-009 real_taken  input  1  resolved direction of the instruction in ID.
REQ-010 real_bjpc  input  32  resolved next PC of the instruction in ID.
REQ-011 pre_fch_wrong  input  1  ID flag: the instruction fetched after the branch was wrong.
REQ-012 pre_taken  output  1  prediction for pc.
REQ-013 pre_bjpc  output  32  predicted next PC for pc.
REQ-014 br_cnt  output  16  count of accepted update events.
REQ-015 miss_cnt  output  16  count of accepted mispredictions.

Function
REQ-016 Each entry SHALL hold: valid (1), tag = pc[31:IDX_W+2], target (32), ctr (2).
REQ-017 Index SHALL be pc[IDX_W+1:2]; upd_pc uses the same index and tag fields.
REQ-018 Lookup SHALL be combinational. hit = valid & tag match. pre_taken = hit & ctr[1].
REQ-019 pre_bjpc SHALL be the entry target when pre_taken = 1, and pc+4 otherwise (32-bit wrap).
REQ-020 ctr encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-021 Updates SHALL occur only on a rising edge with wpcir = 1. A stalled ID (wpcir = 0) SHALL NOT update entries or counters, including when the request is held for multiple cycles.
REQ-022 On ud_BTB: entry[idx(upd_pc)] SHALL get valid=1, tag(upd_pc), target=real_bjpc, and ctr=10 if real_taken, else ctr=01.
REQ-023 On ud_pdt & ~ud_BTB:
 - if the upd_pc entry hits, ctr SHALL saturating-increment when real_taken and saturating-decrement otherwise (11 stays 11, 00 stays 00).
 - if real_taken, target SHALL be rewritten with real_bjpc.
 - if the entry misses, no change.
REQ-024 If ud_BTB and ud_pdt are both high, ud_BTB SHALL take precedence.
REQ-025 When the lookup index equals the update index in the same cycle, lookup SHALL return the pre-edge contents; there is no write bypass.
REQ-026 br_cnt SHALL increment on each accepted edge with wpcir & (ud_BTB | ud_pdt), and saturate at 16'hFFFF.
REQ-027 miss_cnt SHALL increment on each accepted edge with wpcir & pre_fch_wrong, and saturate at 16'hFFFF. Its increment is independent of, and simultaneous with, br_cnt.
REQ-028 No other state SHALL exist; the lookup path SHALL have zero-cycle latency and updates one-cycle latency.

Reset
REQ-029 On rst_n = 0, asynchronously and regardless of clk: all valid=0, all ctr=01, all targets=0, br_cnt=0, miss_cnt=0.
REQ-030 During and immediately after reset, with all entries invalid, outputs SHALL be pre_taken=0 and pre_bjpc=pc+4.
REQ-031 Reset asserted mid-update SHALL discard the update; the state after release SHALL equal the REQ-029 reset state.

Verification
REQ-032 Reset, then pc=0x00400010 -> pre_taken=0, pre_bjpc=0x00400014, br_cnt=0, miss_cnt=0.
REQ-033 ud_BTB=1, wpcir=1, upd_pc=0x00400010, real_taken=1, real_bjpc=0x00400100, then pc=0x00400010 -> pre_taken=1, pre_bjpc=0x00400100, br_cnt=1.
REQ-034 From REQ-033 state, three ud_pdt edges with real_taken=0 -> ctr 10->01->00->00; pre_taken=0, pre_bjpc=0x00400014, br_cnt=4.
REQ-035 Alias test: entry valid for 0x00400010, lookup pc=0x00400050 (same index, different tag) -> pre_taken=0, pre_bjpc=0x00400054; ud_pdt on 0x00400050 leaves the entry unchanged.
REQ-036 Stall test: wpcir=0 with ud_BTB=1 and pre_fch_wrong=1 held for 5 cycles -> no entry change, counters unchanged; one cycle with wpcir=1 -> br_cnt+1, miss_cnt+1.
REQ-037 Force miss_cnt to 0xFFFF via 65535 misses, then one more miss -> miss_cnt stays 0xFFFF. Assert rst_n mid-sequence -> all outputs return to reset values with no clk edge.
